// File: rtl/note_serializer.sv
// note_serializer
// ----------------------------------------------------------------------------
// Transmit side of the note serial link. It takes a snapshot of the note vector
// at the start of each frame. It then shifts the snapshot out LSB-first, one
// bit per BIT_CYCLES-long slot. note_serial_sync is high for all of slot 0 so
// the receiver can align its slot counter to the sync rising edge.
//
// Optional feature (macro NOTE_SER_PARITY_EN):
//   When defined, an extra slot carries even parity (XOR of the snapshot).
//   When undefined, a frame is exactly NUM_NOTES slots long.
//
// Parameters:
//   NUM_NOTES   payload bits per frame
//   BIT_CYCLES  clk cycles per bit slot (>= 128)
//
// Ports:
//   clk               system clock, posedge
//   reset             asynchronous active-high reset
//   enable            level; frames repeat back-to-back while it is high
//   notes             note vector, sampled only at frame start
//   note_serial_sync  frame marker, high for all of slot 0
//   note_serial_data  serial payload bit
//   busy              high while a frame is in flight
//   frame_start       1-cycle pulse on the first cycle of slot 0
//   frame_done        1-cycle pulse on the last cycle of the last slot
// ----------------------------------------------------------------------------
module note_serializer #(
  parameter int NUM_NOTES  = 48,
  parameter int BIT_CYCLES = 8192
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_NOTES-1:0] notes,
  output logic                 note_serial_sync,
  output logic                 note_serial_data,
  output logic                 busy,
  output logic                 frame_start,
  output logic                 frame_done
);

`ifdef NOTE_SER_PARITY_EN
  localparam int FRAME_SLOTS = NUM_NOTES + 1;
`else
  localparam int FRAME_SLOTS = NUM_NOTES;
`endif

  localparam int SW = $clog2(FRAME_SLOTS + 1);
  localparam int CW = $clog2(BIT_CYCLES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME_SLOTS - 1);

  logic [0:0]           state;
  logic [NUM_NOTES-1:0] shreg;
  logic [SW-1:0]        slot;
  logic [CW-1:0]        cyc;

  logic slot_end;
  logic frame_end;
  logic payload_bit;
  logic data_next;
  logic [NUM_NOTES-1:0] slot_hit;

  assign slot_end  = (cyc == CYC_LAST);
  assign frame_end = slot_end && (slot == SLOT_LAST);

  // One-hot selection of the snapshot bit for the current slot. Slots past
  // the payload (the parity slot) select nothing and yield 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_NOTES; gi++) begin : g_sel
      assign slot_hit[gi] = (slot == SW'(gi)) & shreg[gi];
    end
  endgenerate

  assign payload_bit = |slot_hit;

`ifdef NOTE_SER_PARITY_EN
  assign data_next = payload_bit | ((slot == SW'(NUM_NOTES)) & (^shreg));
`else
  assign data_next = payload_bit;
`endif

  // Frame sequencing: snapshot, slot and in-slot cycle counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      slot  <= '0;
      cyc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            shreg <= notes;
            slot  <= '0;
            cyc   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (frame_end) begin
            slot <= '0;
            cyc  <= '0;
            // A new snapshot is taken with no gap, so frames can run back-to-back.
            if (enable) begin
              shreg <= notes;
            end else begin
              state <= IDLE;
            end
          end else if (slot_end) begin
            cyc  <= '0;
            slot <= slot + SW'(1);
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The outputs are a registered image of the counters, one cycle behind.
  // A frame therefore becomes visible one edge after the snapshot edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_serial_sync <= 1'b0;
      note_serial_data <= 1'b0;
      busy             <= 1'b0;
      frame_start      <= 1'b0;
      frame_done       <= 1'b0;
    end else if (state == SEND) begin
      note_serial_sync <= (slot == '0);
      note_serial_data <= data_next;
      busy             <= 1'b1;
      frame_start      <= (slot == '0) && (cyc == '0);
      frame_done       <= frame_end;
    end else begin
      note_serial_sync <= 1'b0;
      note_serial_data <= 1'b0;
      busy             <= 1'b0;
      frame_start      <= 1'b0;
      frame_done       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_note_serializer.sv
// tb_note_serializer
// ----------------------------------------------------------------------------
// Directed bench for note_serializer. It uses a short BIT_CYCLES (128) so that
// whole frames fit in a short run. Outputs are sampled on the falling edge.
// A small receiver model samples data 64 cycles into each slot and rebuilds
// the note vector, which gives a loopback check.
// ----------------------------------------------------------------------------
module tb_note_serializer;

  localparam int NN = 48;
  localparam int BC = 128;
`ifdef NOTE_SER_PARITY_EN
  localparam int FS = NN + 1;
`else
  localparam int FS = NN;
`endif
  localparam int FRAME = FS * BC;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NN-1:0] notes;
  logic          sync;
  logic          data;
  logic          busy;
  logic          fs;
  logic          fd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  note_serializer #(
    .NUM_NOTES (NN),
    .BIT_CYCLES(BC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .notes           (notes),
    .note_serial_sync(sync),
    .note_serial_data(data),
    .busy            (busy),
    .frame_start     (fs),
    .frame_done      (fd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the falling edge of the first cycle of a frame; returns on the
  // falling edge just after the frame's last cycle.
  task automatic run_frame(input string name, input logic [NN-1:0] expv,
                           input int change_t, input logic [NN-1:0] change_val,
                           input logic exp_next);
    logic [FS-1:0] rx;
    logic          exp_bit;
    int            k;
    int            o;
    rx = '0;
    check({name, " start"}, fs, 1);
    for (int t = 0; t < FRAME; t++) begin
      if (t == change_t) notes = change_val;
      k = t / BC;
      o = t % BC;
      exp_bit = (k < NN) ? expv[k] : ^expv;
      if (o == 0 || o == BC - 1) begin
        check({name, " sync"}, sync, (k == 0));
        check({name, " data"}, data, exp_bit);
        check({name, " busy"}, busy, 1);
      end
      if (o == 64) rx[k] = data;
      if (t == 1) check({name, " fs_pulse"}, fs, 0);
      if (t == FRAME - 2) check({name, " fd_early"}, fd, 0);
      if (t == FRAME - 1) check({name, " fd"}, fd, 1);
      @(negedge clk);
    end
    check({name, " rx"}, rx[NN-1:0], expv);
    check({name, " busy_after"}, busy, exp_next);
    check({name, " fs_after"}, fs, exp_next);
    check({name, " sync_after"}, sync, exp_next);
    $display("[TB] frame %s rx=%h", name, rx[NN-1:0]);
  endtask

  initial begin
    // Reset held with enable high: everything stays quiet.
    reset  = 1'b1;
    enable = 1'b1;
    notes  = 48'h8000_0000_0001;
    repeat (5) @(negedge clk);
    check("rst_outs", {sync, data, busy, fs, fd}, 0);
    $display("[TB] reset held, outs=%b", {sync, data, busy, fs, fd});

    // Release: the first edge snapshots, the next edge shows the frame.
    reset = 1'b0;
    @(negedge clk);
    check("idle_latency", busy, 0);
    @(negedge clk);
    enable = 1'b0;
    run_frame("single", 48'h8000_0000_0001, -1, '0, 1'b0);

    // Back-to-back, with notes changing mid-frame (snapshot isolation).
    enable = 1'b1;
    @(negedge clk);
    check("b2b_idle", busy, 0);
    @(negedge clk);
    run_frame("snap", 48'h8000_0000_0001, 10 * BC + 5, '1, 1'b1);
    enable = 1'b0;
    run_frame("ones", '1, -1, '0, 1'b0);

    // Reset asserted in slot 10 clears outputs without a clock edge.
    notes  = 48'hA5A5_3C3C_0F0F;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_start", fs, 1);
    enable = 1'b0;
    repeat (10 * BC + 3) @(negedge clk);
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1 check("rst_async", {sync, data, busy, fs, fd}, 0);
    $display("[TB] async reset in slot 10, outs=%b", {sync, data, busy, fs, fd});
    @(negedge clk);
    enable = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 0);
    @(negedge clk);
    enable = 1'b0;
    run_frame("loop", 48'hA5A5_3C3C_0F0F, -1, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
